// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage with valid/ready flow control, flush and an optional
// 2-entry skid buffer so MEM can stall without a combinational ready path into EX.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 12,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   live;
  logic   in_fire, out_fire;
  logic   load_main_in, load_main_skid, load_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  // live keeps in_ready low during reset and for the reset cycle itself.
  generate
    if (SKID) begin : g_skid_ready
      assign in_ready = live & (state != FULL);
    end else begin : g_pass_ready
      assign in_ready = live & (~out_valid | out_ready);
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && (out_fire || !SKID)) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: payload registers are cleared by reset so out_data reads zero after
  // reset; otherwise they only load on an accepted entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: a SKID=1 and a SKID=0 instance share stimulus,
// each with its own queue scoreboard plus directed checks.
module tb_ex_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_ctrl = '0;
  logic [95:0] in_data = '0;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [11:0] a_out_ctrl, b_out_ctrl;
  logic [95:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  logic [107:0] sb_q[2][$];
  bit           live_m[2];

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.DATA_W(96), .CTRL_W(12), .SKID(1'b1)) u_dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .occupancy(a_occ)
  );

  ex_mem_pipe_stage #(.DATA_W(96), .CTRL_W(12), .SKID(1'b0)) u_dut_reg (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occupancy(b_occ)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: queue holds what the stage should currently contain.
  task automatic sb_step(input int k, input bit skid, input logic rdy, input logic vld,
                         input logic [11:0] ctl, input logic [95:0] dat, input logic [1:0] occ);
    logic [107:0] e;
    logic         exp_rdy;
    int           n;
    n = sb_q[k].size();
    exp_rdy = live_m[k] && (skid ? (n < 2) : ((n == 0) || out_ready));
    check($sformatf("sb%0d_in_ready", k), rdy, exp_rdy);
    check($sformatf("sb%0d_occupancy", k), occ, n);
    check($sformatf("sb%0d_out_valid", k), vld, n != 0);
    if (!vld) check($sformatf("sb%0d_bubble_ctrl", k), ctl, 0);
    if (vld && out_ready && n > 0) begin
      e = sb_q[k].pop_front();
      check($sformatf("sb%0d_ctrl", k), ctl, e[107:96]);
      check($sformatf("sb%0d_data", k), dat, e[95:0]);
    end
    if (reset || flush) sb_q[k].delete();
    else if (in_valid && rdy) sb_q[k].push_back({in_ctrl, in_data});
    live_m[k] = !reset;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      sb_step(0, 1'b1, a_in_ready, a_out_valid, a_out_ctrl, a_out_data, a_occ);
      sb_step(1, 1'b0, b_in_ready, b_out_valid, b_out_ctrl, b_out_data, b_occ);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold an entry on the input until the selected instance accepts it.
  task automatic push(input bit use_b, input logic [11:0] c, input logic [95:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = use_b ? b_in_ready : a_in_ready;
      @(posedge clk);
      #1;
      if (ok) return;
    end
    check("push_timeout", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ok;
    live_m[0] = 1'b0;
    live_m[1] = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1);
    @(negedge clk);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_in_ready", a_in_ready, 0);
    reset = 1'b0;
    step(1);
    @(negedge clk);
    check("post_rst_in_ready", a_in_ready, 1);

    // 1: single entry, one-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 12'h0A5;
    in_data   = 96'h1234;
    step(1);
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", a_out_valid, 1);
    check("t1_out_ctrl", a_out_ctrl, 12'h0A5);
    check("t1_out_data", a_out_data, 96'h1234);
    check("t1_occupancy", a_occ, 1);
    step(2);

    // 2: fill skid with MEM stalled, then drain in order
    out_ready = 1'b0;
    push(1'b0, 12'h00A, 96'hA);
    push(1'b0, 12'h00B, 96'hB);
    in_ctrl = 12'h00C;
    in_data = 96'hC;
    @(negedge clk);
    check("t2_in_ready", a_in_ready, 0);
    check("t2_occupancy", a_occ, 2);
    step(2);
    check("t2_still_full", a_occ, 2);
    out_ready = 1'b1;
    push(1'b0, 12'h00C, 96'hC);
    in_valid = 1'b0;
    step(4);

    // 3: streaming, one entry per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_ctrl = 12'($urandom);
      in_data = {$urandom, $urandom, $urandom};
      @(negedge clk);
      check("t3_in_ready", a_in_ready, 1);
      if (i > 0) check("t3_out_valid", a_out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    step(3);

    // 4: flush while FULL with an input presented
    out_ready = 1'b0;
    push(1'b0, 12'h111, 96'h111);
    push(1'b0, 12'h222, 96'h222);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_ctrl  = 12'hFFF;
    in_data  = 96'hDEAD;
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_out_valid", a_out_valid, 0);
    check("t4_out_ctrl", a_out_ctrl, 0);
    check("t4_occupancy", a_occ, 0);
    check("t4_in_ready", a_in_ready, 1);
    out_ready = 1'b1;
    step(4);

    // 5: single-register mode with toggling out_ready
    cnt = 0;
    in_valid = 1'b1;
    in_ctrl  = 12'h500;
    in_data  = 96'h0;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      @(negedge clk);
      if (b_out_valid) check("t5_mirror", b_in_ready, out_ready);
      ok = b_in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        cnt++;
        in_ctrl = 12'h500 + 12'(cnt);
        in_data = 96'(cnt);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(4);

    // 6: reset while FULL
    out_ready = 1'b0;
    push(1'b0, 12'h333, 96'h333);
    push(1'b0, 12'h444, 96'h444);
    in_valid = 1'b0;
    @(negedge clk);
    check("t6_pre_occ", a_occ, 2);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    check("t6_out_valid", a_out_valid, 0);
    check("t6_out_ctrl", a_out_ctrl, 0);
    check("t6_out_data", a_out_data, 0);
    check("t6_occupancy", a_occ, 0);
    check("t6_in_ready", a_in_ready, 0);
    reset = 1'b0;
    step(1);
    @(negedge clk);
    check("t6_release_in_ready", a_in_ready, 1);
    out_ready = 1'b1;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
